usb_tx_mass_gen: RTL and testbench

Bulk-transfer test generator that sits between the user side of the FT232H 245-FIFO controller's RX and TX AXI-streams. It collects a 4-byte little-endian length header from the 8-bit RX stream. It then emits exactly that many bytes of an incrementing byte pattern on the 32-bit TX stream, with `tkeep`/`tlast` framing. Host throughput tests use it to drive mass USB uploads from a single small command.

---
 rtl/usb_tx_mass_gen.sv | 163 ++++++++++++++++
 tb/tb_usb_tx_mass_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_mass_gen.sv
// Bulk test generator: 4-byte LE length header in on RX, incrementing byte pattern out on 32-bit TX; first word 2 cycles after last header byte.
// TX word held while tx_tready low; RX stalled while sending. Optional partial-header timeout via USB_TX_MASS_TIMEOUT_EN.
module usb_tx_mass_gen #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  START_BYTE  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_tvalid,
  input  logic [7:0]  rx_tdata,
  output logic        rx_tready,
  input  logic        tx_tready,
  output logic        tx_tvalid,
  output logic [31:0] tx_tdata,
  output logic [3:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_HDR, S_LOAD, S_SEND} state_t;

  state_t      state_q;
  logic [1:0]  hdr_cnt_q;
  logic [31:0] len_q;
  logic [31:0] rem_q;
  logic [7:0]  pat_q;
  logic        tx_tvalid_q;
  logic [31:0] tx_tdata_q;
  logic [3:0]  tx_tkeep_q;
  logic        tx_tlast_q;
  logic        busy_q;
  logic        done_q;

  logic        rx_hs;
  logic        tx_hs;
  logic [31:0] rem_d;
  logic [7:0]  pat_d;
  logic [31:0] word_dat_d;
  logic [3:0]  word_keep_d;
  logic        word_last_d;

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be nonzero");
  end

  assign rx_tready = (state_q == S_HDR) & ~rst;
  assign rx_hs     = rx_tvalid & rx_tready;
  assign tx_hs     = tx_tvalid_q & tx_tready;

  // Word to present next: first word of a packet in S_LOAD, otherwise the one after the current word.
  always_comb begin
    if (state_q == S_LOAD) begin
      rem_d = len_q;
      pat_d = START_BYTE;
    end else begin
      rem_d = rem_q - 32'd4;
      pat_d = pat_q + 8'd4;
    end
    word_dat_d  = '0;
    word_keep_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (rem_d > 32'(i)) begin
        word_dat_d[8*i +: 8] = pat_d + 8'(i);
        word_keep_d[i]       = 1'b1;
      end
    end
    word_last_d = (rem_d <= 32'd4);
  end

`ifdef USB_TX_MASS_TIMEOUT_EN
  logic [31:0] tmo_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      hdr_cnt_q   <= 2'd0;
      len_q       <= '0;
      rem_q       <= '0;
      pat_q       <= '0;
      tx_tvalid_q <= 1'b0;
      tx_tdata_q  <= '0;
      tx_tkeep_q  <= '0;
      tx_tlast_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef USB_TX_MASS_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_HDR: begin
          if (rx_hs) begin
            len_q[{hdr_cnt_q, 3'b000} +: 8] <= rx_tdata;
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd3) begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
            end
          end
`ifdef USB_TX_MASS_TIMEOUT_EN
          // Stale partial headers are dropped after TIMEOUT_CYC quiet cycles.
          if (rx_hs || hdr_cnt_q == 2'd0) begin
            tmo_q <= '0;
          end else if (tmo_q == TIMEOUT_CYC - 1) begin
            tmo_q     <= '0;
            hdr_cnt_q <= 2'd0;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
`endif
        end
        S_LOAD: begin
          rem_q <= rem_d;
          pat_q <= pat_d;
          if (len_q == 32'd0) begin
            done_q    <= 1'b1;
            hdr_cnt_q <= 2'd0;
            busy_q    <= 1'b0;
            state_q   <= S_HDR;
          end else begin
            tx_tvalid_q <= 1'b1;
            tx_tdata_q  <= word_dat_d;
            tx_tkeep_q  <= word_keep_d;
            tx_tlast_q  <= word_last_d;
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_hs) begin
            if (tx_tlast_q) begin
              tx_tvalid_q <= 1'b0;
              tx_tdata_q  <= '0;
              tx_tkeep_q  <= '0;
              tx_tlast_q  <= 1'b0;
              done_q      <= 1'b1;
              hdr_cnt_q   <= 2'd0;
              busy_q      <= 1'b0;
              state_q     <= S_HDR;
            end else begin
              rem_q      <= rem_d;
              pat_q      <= pat_d;
              tx_tdata_q <= word_dat_d;
              tx_tkeep_q <= word_keep_d;
              tx_tlast_q <= word_last_d;
            end
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign tx_tvalid = tx_tvalid_q;
  assign tx_tdata  = tx_tdata_q;
  assign tx_tkeep  = tx_tkeep_q;
  assign tx_tlast  = tx_tlast_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_usb_tx_mass_gen.sv
// Bench for usb_tx_mass_gen: random TX backpressure against a byte-level packet model.
module tb_usb_tx_mass_gen;

  localparam logic [7:0] START = 8'h00;

  logic        clk;
  logic        rst;
  logic        rx_tvalid;
  logic [7:0]  rx_tdata;
  logic        rx_tready;
  logic        tx_tready;
  logic        tx_tvalid;
  logic [31:0] tx_tdata;
  logic [3:0]  tx_tkeep;
  logic        tx_tlast;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  usb_tx_mass_gen #(.TIMEOUT_CYC(16), .START_BYTE(START)) dut (
    .clk(clk), .rst(rst),
    .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tready(rx_tready),
    .tx_tready(tx_tready), .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet of L bytes is the byte stream START, START+1, ... packed 4 per word, lane 0 first.
  function automatic void exp_word(input longint L, input longint idx,
                                   output logic [31:0] d, output logic [3:0] k, output logic l);
    d = '0;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      longint b = idx * 4 + i;
      if (b < L) begin
        d[8*i +: 8] = START + 8'(b);
        k[i] = 1'b1;
      end
    end
    l = (idx * 4 + 4 >= L);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_tvalid = 1'b1;
    rx_tdata  = b;
    while (rx_tready !== 1'b1 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL rx_accept: rx_tready=%b never 1 within 200 cycles", rx_tready);
    end
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
  endtask

  // Called in the cycle after the 4th header byte was accepted.
  task automatic collect(input int unsigned L, input int pct, input string name);
    int nwords = (L + 3) / 4;
    int idx = 0;
    int cyc = 0;
    int first_cyc = -1;
    bit bad_done = 0, bad_rx = 0, bad_busy = 0, bad_drop = 0;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    checks++;
    if ({busy, rx_tready, tx_tvalid, done} !== 4'b1000) begin
      errors++;
      $display("FAIL %s load_cycle: busy,rx_tready,tx_tvalid,done=%b want 1000", name,
               {busy, rx_tready, tx_tvalid, done});
    end
    if (L == 0) begin
      @(posedge clk); #1;
      checks++;
      if ({done, rx_tready, tx_tvalid, busy} !== 4'b1100) begin
        errors++;
        $display("FAIL %s zero_done: done,rx_tready,tx_tvalid,busy=%b want 1100", name,
                 {done, rx_tready, tx_tvalid, busy});
      end
    end else begin
      while (idx < nwords && cyc < 5000) begin
        @(posedge clk); #1; cyc++;
        if (done) bad_done = 1;
        if (rx_tready) bad_rx = 1;
        if (!busy) bad_busy = 1;
        if (!tx_tvalid && first_cyc >= 0) bad_drop = 1;
        tx_tready = ($urandom_range(99) < pct);
        if (tx_tvalid) begin
          if (first_cyc < 0) first_cyc = cyc;
          exp_word(L, idx, ed, ek, el);
          checks++;
          if ({tx_tdata, tx_tkeep, tx_tlast} !== {ed, ek, el}) begin
            errors++;
            $display("FAIL %s word%0d: got data=%h keep=%b last=%b want data=%h keep=%b last=%b",
                     name, idx, tx_tdata, tx_tkeep, tx_tlast, ed, ek, el);
          end
          if (tx_tready) idx++;
        end
      end
      checks++;
      if (idx != nwords) begin
        errors++;
        $display("FAIL %s word_count: got %0d words want %0d (cycle budget)", name, idx, nwords);
      end
      checks++;
      if (first_cyc != 1) begin
        errors++;
        $display("FAIL %s first_valid_latency: got %0d cycles after load want 1", name, first_cyc);
      end
      checks++;
      if (bad_done || bad_rx || bad_busy || bad_drop) begin
        errors++;
        $display("FAIL %s in_packet: early_done=%b rx_tready_seen=%b busy_low=%b valid_drop=%b want 0000",
                 name, bad_done, bad_rx, bad_busy, bad_drop);
      end
      if (pct >= 100) begin
        checks++;
        if (cyc != nwords) begin
          errors++;
          $display("FAIL %s throughput: got %0d cycles want %0d", name, cyc, nwords);
        end
      end
      @(posedge clk); #1;
      checks++;
      if ({done, rx_tready, tx_tvalid, busy} !== 4'b1100) begin
        errors++;
        $display("FAIL %s end_done: done,rx_tready,tx_tvalid,busy=%b want 1100", name,
                 {done, rx_tready, tx_tvalid, busy});
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_single: done=%b want 0", name, done);
    end
  endtask

  task automatic do_packet(input int unsigned L, input int pct, input string name);
    send_hdr(32'(L));
    collect(L, pct, name);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, busy, done} !== 39'd0) begin
      errors++;
      $display("FAIL %s: tvalid=%b tdata=%h tkeep=%b tlast=%b busy=%b done=%b want all 0",
               name, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_tvalid = 1'b0; rx_tdata = '0; tx_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_outputs");
    checks++;
    if (rx_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_rx_tready: got %b want 0", rx_tready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rx_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rx_tready: got %b want 1", rx_tready);
    end
  endtask

  task automatic test_basic();
    do_packet(4, 100, "len4");
    do_packet(7, 100, "len7");
    do_packet(0, 100, "len0");
  endtask

  task automatic test_wrap_300();
    do_packet(300, 50, "len300");
  endtask

  task automatic test_partial_header();
`ifdef USB_TX_MASS_TIMEOUT_EN
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (16) @(posedge clk);
    #1;
    do_packet(5, 100, "timeout_len5");
`else
    send_byte(8'h05);
    send_byte(8'h00);
    repeat (40) @(posedge clk);
    #1;
    send_byte(8'h00);
    send_byte(8'h00);
    collect(5, 100, "held_len5");
`endif
  endtask

  task automatic test_back_to_back();
    send_hdr(32'd8);
    rx_tvalid = 1'b1;
    rx_tdata  = 8'h03;
    collect(8, 100, "b2b_first");
    rx_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    collect(3, 70, "b2b_second");
  endtask

  task automatic test_rst_mid();
    tx_tready = 1'b0;
    send_hdr(32'd16);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({tx_tvalid, tx_tdata, tx_tkeep, tx_tlast} !== {1'b1, 32'h03020100, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL stall_hold: got valid=%b data=%h keep=%b last=%b want 1 03020100 1111 0",
               tx_tvalid, tx_tdata, tx_tkeep, tx_tlast);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("rst_mid_outputs");
    checks++;
    if (rx_tready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rx_tready: got %b want 0", rx_tready);
    end
    rst = 1'b0;
    #1;
    do_packet(9, 50, "after_rst_len9");
  endtask

  task automatic test_max_len();
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    tx_tready = 1'b1;
    send_hdr(32'hFFFF_FFFF);
    for (int w = 0; w < 4; w++) begin
      @(posedge clk); #1;
      exp_word(64'h0000_0000_FFFF_FFFF, w, ed, ek, el);
      checks++;
      if ({tx_tvalid, tx_tdata, tx_tkeep, tx_tlast} !== {1'b1, ed, ek, el}) begin
        errors++;
        $display("FAIL maxlen word%0d: got valid=%b data=%h keep=%b last=%b want 1 %h %b %b",
                 w, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, ed, ek, el);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("maxlen_rst");
    rst = 1'b0;
    #1;
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      do_packet($urandom_range(1, 40), $urandom_range(30, 100), $sformatf("rand%0d", p));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_300();
    test_partial_header();
    test_back_to_back();
    test_rst_mid();
    test_max_len();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
